// File: rtl/emergency_response_ctrl_pkg.sv
// Shared definitions for the emergency response controller.
//   state_t       : FSM state encoding, also the value driven on state_o
//   *_DEF         : default timing parameters, in clk_i cycles
package emergency_response_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALERT = 2'd2,
        ST_ACKED = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int BEEP_PERIOD_DEF  = 8;
    localparam int SILENCE_CYC_DEF  = 16;

endpackage

// File: rtl/emergency_debounce.sv
// Level qualifier for one raw input.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   level_i : raw level
//   qual_o  : high while level_i has been high for DEBOUNCE_CYC earlier cycles
//             and is still high now
module emergency_debounce
    import emergency_response_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic qual_o
);

    localparam int            CW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !level_i) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Gating with the live level means a level that drops on the very cycle it
    // would have qualified is rejected, so a pulse of exactly DEBOUNCE_CYC
    // cycles never qualifies.
    assign qual_o = level_i && (cnt == CNT_MAX);

endmodule

// File: rtl/emergency_response_ctrl.sv
// Alarm controller between the emergency detector and the home actuators.
// Qualifies the water warning and gas alert levels, latches an alarm state,
// drives buzzer/LEDs/valves and releases only after acknowledge plus all-clear.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   warning_i, alert_i    : raw water-warning / gas-alert levels
//   user_ack_i            : acknowledge (pulse or level)
//   water_valve_close_o   : 1 = close water main (sticky until ACKED->IDLE)
//   gas_valve_close_o     : 1 = close gas main (sticky until ACKED->IDLE)
//   buzzer_o              : beep pattern in WARN / ALERT
//   warning_led_o         : WARN, or ACKED after a warning
//   alert_led_o           : ALERT, or ACKED after an alert
//   state_o               : current state (0 IDLE, 1 WARN, 2 ALERT, 3 ACKED)
module emergency_response_ctrl
    import emergency_response_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int BEEP_PERIOD  = BEEP_PERIOD_DEF,
    parameter int SILENCE_CYC  = SILENCE_CYC_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       warning_i,
    input  logic       alert_i,
    input  logic       user_ack_i,
    output logic       water_valve_close_o,
    output logic       gas_valve_close_o,
    output logic       buzzer_o,
    output logic       warning_led_o,
    output logic       alert_led_o,
    output logic [1:0] state_o
);

    localparam int               PH_W       = $clog2(4 * BEEP_PERIOD);
    localparam int               SIL_W      = $clog2(SILENCE_CYC + 1);
    localparam logic [PH_W-1:0]  WARN_WRAP  = PH_W'(4 * BEEP_PERIOD - 1);
    localparam logic [PH_W-1:0]  ALERT_WRAP = PH_W'(2 * BEEP_PERIOD - 1);
    localparam logic [PH_W-1:0]  BEEP_LIM   = PH_W'(BEEP_PERIOD);
    localparam logic [SIL_W-1:0] SIL_MAX    = SIL_W'(SILENCE_CYC);

    state_t             state, state_n;
    logic               warn_q, alert_q, clear_q;
    logic               water_close, gas_close;
    logic               warn_seen, alert_seen;
    logic               from_warn;
    logic [PH_W-1:0]    phase_cnt;
    logic [SIL_W-1:0]   silence_cnt;
    logic               snooze_done;

    emergency_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_warn (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .level_i(warning_i),
        .qual_o (warn_q)
    );

    emergency_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_alert (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .level_i(alert_i),
        .qual_o (alert_q)
    );

    emergency_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_clear (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .level_i(~(warning_i | alert_i)),
        .qual_o (clear_q)
    );

    // silence_cnt is loaded with 1 on entry so it equals the number of cycles
    // already spent in ACKED; the snooze expires after SILENCE_CYC of them.
    assign snooze_done = (silence_cnt == SIL_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (alert_q) begin
                    state_n = ST_ALERT;
                end else if (warn_q) begin
                    state_n = ST_WARN;
                end
            end
            ST_WARN: begin
                if (alert_q) begin
                    state_n = ST_ALERT;
                end else if (user_ack_i) begin
                    state_n = ST_ACKED;
                end
            end
            ST_ALERT: begin
                if (user_ack_i) begin
                    state_n = ST_ACKED;
                end
            end
            ST_ACKED: begin
                if (clear_q) begin
                    state_n = ST_IDLE;
                end else if (from_warn && alert_q) begin
                    state_n = ST_ALERT;
                end else if (snooze_done) begin
                    if (alert_q) begin
                        state_n = ST_ALERT;
                    end else if (warn_q) begin
                        state_n = ST_WARN;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            water_close <= 1'b0;
            gas_close   <= 1'b0;
            warn_seen   <= 1'b0;
            alert_seen  <= 1'b0;
            from_warn   <= 1'b0;
            phase_cnt   <= '0;
            silence_cnt <= '0;
        end else if (state_n != state) begin
            phase_cnt   <= '0;
            silence_cnt <= SIL_W'(1);
            case (state_n)
                ST_WARN: begin
                    water_close <= 1'b1;
                    warn_seen   <= 1'b1;
                end
                ST_ALERT: begin
                    gas_close  <= 1'b1;
                    alert_seen <= 1'b1;
                    // A direct jump to ALERT skipped the WARN closure of water.
                    if (state == ST_IDLE) begin
                        water_close <= 1'b1;
                    end
                end
                ST_ACKED: from_warn <= (state == ST_WARN);
                default: begin
                    water_close <= 1'b0;
                    gas_close   <= 1'b0;
                    warn_seen   <= 1'b0;
                    alert_seen  <= 1'b0;
                    from_warn   <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                ST_WARN:  phase_cnt <= (phase_cnt == WARN_WRAP)  ? '0 : phase_cnt + PH_W'(1);
                ST_ALERT: phase_cnt <= (phase_cnt == ALERT_WRAP) ? '0 : phase_cnt + PH_W'(1);
                default:  phase_cnt <= '0;
            endcase
            if (state == ST_ACKED && !snooze_done) begin
                silence_cnt <= silence_cnt + SIL_W'(1);
            end
        end
    end

    assign state_o             = state;
    assign water_valve_close_o = water_close;
    assign gas_valve_close_o   = gas_close;
    assign buzzer_o            = ((state == ST_WARN) || (state == ST_ALERT)) && (phase_cnt < BEEP_LIM);
    assign warning_led_o       = (state == ST_WARN)  || ((state == ST_ACKED) && warn_seen);
    assign alert_led_o         = (state == ST_ALERT) || ((state == ST_ACKED) && alert_seen);

endmodule

// File: tb/tb_emergency_response_ctrl.sv
// Bench for emergency_response_ctrl: directed scenarios followed by random
// input segments, every cycle compared with a behavioural model.
module tb_emergency_response_ctrl;

    localparam int DEB  = 4;
    localparam int BEEP = 8;
    localparam int SIL  = 16;

    localparam int S_IDLE  = 0;
    localparam int S_WARN  = 1;
    localparam int S_ALERT = 2;
    localparam int S_ACKED = 3;

    logic       clk = 1'b0;
    logic       rst, warning, alert, ack;
    logic       water, gas, buzzer, wled, aled;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int m_state, m_t, m_wrun, m_arun, m_crun;
    bit m_water, m_gas, m_wseen, m_aseen, m_from_warn;

    emergency_response_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .BEEP_PERIOD (BEEP),
        .SILENCE_CYC (SIL)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .warning_i          (warning),
        .alert_i            (alert),
        .user_ack_i         (ack),
        .water_valve_close_o(water),
        .gas_valve_close_o  (gas),
        .buzzer_o           (buzzer),
        .warning_led_o      (wled),
        .alert_led_o        (aled),
        .state_o            (state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_t = 0;
        m_wrun = 0; m_arun = 0; m_crun = 0;
        m_water = 0; m_gas = 0; m_wseen = 0; m_aseen = 0; m_from_warn = 0;
    endtask

    // An input is qualified at an edge when it was high at the previous DEB
    // edges and is still high at this one.
    task automatic model_edge(input bit r, input bit w, input bit a, input bit k);
        bit wq, aq, cq, c;
        int ns;
        if (r) begin
            model_reset();
            return;
        end
        c  = !(w || a);
        wq = w && (m_wrun >= DEB);
        aq = a && (m_arun >= DEB);
        cq = c && (m_crun >= DEB);
        m_wrun = w ? m_wrun + 1 : 0;
        m_arun = a ? m_arun + 1 : 0;
        m_crun = c ? m_crun + 1 : 0;
        ns = m_state;
        case (m_state)
            S_IDLE:  if (aq) ns = S_ALERT; else if (wq) ns = S_WARN;
            S_WARN:  if (aq) ns = S_ALERT; else if (k) ns = S_ACKED;
            S_ALERT: if (k) ns = S_ACKED;
            default: begin
                if (cq) ns = S_IDLE;
                else if (m_from_warn && aq) ns = S_ALERT;
                else if (m_t + 1 >= SIL) begin
                    if (aq) ns = S_ALERT; else if (wq) ns = S_WARN;
                end
            end
        endcase
        if (ns != m_state) begin
            case (ns)
                S_WARN:  begin m_water = 1; m_wseen = 1; end
                S_ALERT: begin m_gas = 1; m_aseen = 1; if (m_state == S_IDLE) m_water = 1; end
                S_ACKED: m_from_warn = (m_state == S_WARN);
                default: begin
                    m_water = 0; m_gas = 0; m_wseen = 0; m_aseen = 0; m_from_warn = 0;
                end
            endcase
            m_t = 0;
        end else begin
            m_t++;
        end
        m_state = ns;
    endtask

    task automatic cyc(input bit w, input bit a, input bit k);
        bit eb;
        warning = w; alert = a; ack = k;
        @(posedge clk);
        model_edge(rst, w, a, k);
        #1;
        eb = (m_state == S_WARN  && (m_t % (4 * BEEP)) < BEEP) ||
             (m_state == S_ALERT && (m_t % (2 * BEEP)) < BEEP);
        check("m_state",  state,  m_state);
        check("m_water",  water,  m_water);
        check("m_gas",    gas,    m_gas);
        check("m_buzzer", buzzer, eb);
        check("m_wled",   wled,   (m_state == S_WARN)  || (m_state == S_ACKED && m_wseen));
        check("m_aled",   aled,   (m_state == S_ALERT) || (m_state == S_ACKED && m_aseen));
    endtask

    initial begin
        int n;
        model_reset();
        rst = 1; warning = 0; alert = 0; ack = 0;
        repeat (2) cyc(0, 0, 0);
        check("rst_state", state, 0);
        check("rst_valves", {water, gas}, 0);
        check("rst_ind", {buzzer, wled, aled}, 0);
        rst = 0;

        // 1: a 4-cycle warning is rejected, a 5-cycle one latches WARN
        repeat (4) cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        check("t1_short_pulse", state, S_IDLE);
        repeat (4) cyc(1, 0, 0);
        check("t1_not_yet", state, S_IDLE);
        cyc(1, 0, 0);
        check("t1_warn", state, S_WARN);
        check("t1_water", water, 1);
        n = buzzer;
        for (int i = 1; i < 4 * BEEP; i++) begin
            cyc(0, 0, 0);
            n += buzzer;
        end
        check("t1_beep_on", n, BEEP);
        check("t1_latched", state, S_WARN);

        // 2: alert escalates over a same-cycle ack
        repeat (4) cyc(0, 1, 0);
        cyc(0, 1, 1);
        check("t2_alert", state, S_ALERT);
        check("t2_gas", gas, 1);
        n = buzzer;
        for (int i = 1; i < 2 * BEEP; i++) begin
            cyc(0, 1, 0);
            n += buzzer;
        end
        check("t2_beep_on", n, BEEP);

        // 3: ack, then all-clear releases
        cyc(0, 1, 1);
        check("t3_acked", state, S_ACKED);
        check("t3_buzzer", buzzer, 0);
        check("t3_valves", {water, gas}, 2'b11);
        check("t3_leds", {wled, aled}, 2'b11);
        n = 0;
        while (state != S_IDLE && n < 20) begin
            cyc(0, 0, 0);
            n++;
        end
        check("t3_clear_latency", n, DEB + 1);
        check("t3_valves_open", {water, gas}, 0);
        check("t3_leds_off", {wled, aled}, 0);

        // 4: snooze re-arm from ACKED with alert still present
        repeat (DEB + 1) cyc(0, 1, 0);
        check("t4_alert", state, S_ALERT);
        cyc(0, 1, 1);
        n = 0;
        while (state != S_ALERT && n < 40) begin
            cyc(0, 1, 0);
            n++;
        end
        check("t4_snooze_len", n, SIL);
        check("t4_buzzer_restart", buzzer, 1);
        cyc(0, 1, 1);
        check("t4_reack", state, S_ACKED);

        // 5: ACKED from WARN escalates on alert before snooze expiry
        n = 0;
        while (state != S_IDLE && n < 20) begin
            cyc(0, 0, 0);
            n++;
        end
        check("t5_idle", state, S_IDLE);
        repeat (DEB + 1) cyc(1, 0, 0);
        cyc(1, 0, 1);
        check("t5_acked", state, S_ACKED);
        check("t5_gas_open", gas, 0);
        n = 0;
        while (state == S_ACKED && n < 40) begin
            cyc(1, 1, 0);
            n++;
        end
        check("t5_escalate", state, S_ALERT);
        check("t5_latency", n, DEB + 1);
        check("t5_gas", gas, 1);

        // 6: reset mid-alarm, then re-detection
        rst = 1;
        cyc(1, 1, 0);
        check("t6_rst_state", state, S_IDLE);
        check("t6_rst_outs", {water, gas, buzzer, wled, aled}, 0);
        rst = 0;
        n = 0;
        while (state != S_ALERT && n < 20) begin
            cyc(0, 1, 0);
            n++;
        end
        check("t6_redetect", n, DEB + 1);

        // random segments checked cycle by cycle against the model
        for (int s = 0; s < 150; s++) begin
            bit w, a;
            int len;
            w   = ($urandom_range(0, 2) == 0);
            a   = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                rst = ($urandom_range(0, 299) == 0);
                cyc(w, a, $urandom_range(0, 9) == 0);
            end
            rst = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
